// File: rtl/uart_rx_fifo_if.sv
// Byte stream from UartRx into the receive FIFO, and the memory-mapped read side.
// The slave modport is the FIFO; master is whoever drives the receiver and read strobes.
interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  uartrx_dr;
  logic [7:0]            uartrx_data;
  logic                  uartrx_go;
  logic                  rd;
  logic [7:0]            dout;
  logic                  empty;
  logic                  full;
  logic [DEPTH_LOG2:0]   count;
  logic                  overrun;
  logic                  clr_overrun;

  modport master (
    output uartrx_dr, uartrx_data, rd, clr_overrun,
    input  uartrx_go, dout, empty, full, count, overrun
  );

  modport slave (
    input  uartrx_dr, uartrx_data, rd, clr_overrun,
    output uartrx_go, dout, empty, full, count, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO: acknowledges each UartRx byte with a one-cycle go drop, show-ahead head on dout.
// Full FIFO drops incoming bytes (still acknowledged) and sets a sticky overrun; rd on empty is ignored.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input logic           clk,
  input logic           rst,
  uart_rx_fifo_if.slave bus
);
  localparam int                    DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic {RECV = 1'b0, ACK = 1'b1} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wp;
  logic [DEPTH_LOG2-1:0] rp;
  logic [DEPTH_LOG2:0]   count;
  logic                  overrun;
  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  accept;
  logic                  drop;

  assign empty  = (count == '0);
  assign full   = (count == CNT_FULL);
  assign push   = (state == RECV) && bus.uartrx_dr;
  assign pop    = bus.rd && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  always_comb begin
    state_nxt = state;
    case (state)
      RECV: if (bus.uartrx_dr) state_nxt = ACK;
      ACK:  state_nxt = RECV;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RECV;
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) wp <= wp + PTR_ONE;
      if (pop)    rp <= rp + PTR_ONE;
      if (accept && !pop)      count <= count + CNT_ONE;
      else if (pop && !accept) count <= count - CNT_ONE;
      if (drop)                 overrun <= 1'b1;
      else if (bus.clr_overrun) overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wp] <= bus.uartrx_data;
  end

  assign bus.uartrx_go = (state == RECV);
  assign bus.dout      = empty ? 8'h00 : mem[rp];
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.count     = count;
  assign bus.overrun   = overrun;
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer between the `UartRx` receiver and the RAMIO memory-mapped UART-in register. It owns the `UartRx` go/dr acknowledge handshake and stores each received byte in a small FIFO. Software reads bytes one at a time, so bytes that arrive back-to-back are not lost. It also reports fill level and a sticky overrun flag.

## Interface
Parameters:
- `DEPTH_LOG2`, default 4: FIFO depth is 2**DEPTH_LOG2 bytes (16).

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `uartrx_dr` in 1: data ready from `UartRx`.
- `uartrx_data` in 8: received byte from `UartRx`; valid while `uartrx_dr`=1.
- `uartrx_go` out 1: receive enable to `UartRx`; low for one cycle acknowledges a byte.
- `rd` in 1: pop strobe from the memory-mapped read path (one pulse per byte read).
- `dout` in/out: out 8: head byte; 0 when empty.
- `empty` out 1: FIFO holds no bytes.
- `full` out 1: FIFO holds 2**DEPTH_LOG2 bytes.
- `count` out DEPTH_LOG2+1: number of stored bytes, 0..2**DEPTH_LOG2.
- `overrun` out 1: sticky; set when a byte was dropped because the FIFO was full.
- `clr_overrun` in 1: clears `overrun`.

## Operation
- Storage: register array of 2**DEPTH_LOG2 x 8, with write pointer `wp` and read pointer `rp`, each DEPTH_LOG2 bits.
- Pointers wrap modulo depth. `count` is kept explicitly, with no pointer-MSB trick.
- `empty` = (count==0). `full` = (count==2**DEPTH_LOG2). Both are derived from the registered `count`.
- `dout` = mem[rp] when !empty, else 8'h00. It is combinational from registered state (show-ahead).
- Handshake FSM, two states:
  - RECV (`uartrx_go`=1): if `uartrx_dr`=1 at an edge, the byte is offered to the FIFO and the next state is ACK.
  - ACK (`uartrx_go`=0): unconditionally returns to RECV at the next edge. `uartrx_dr` is ignored in ACK.
- `uartrx_go` is a registered output equal to (state==RECV).
- Push rules:
  - push = RECV && `uartrx_dr`.
  - If !full, or a pop happens in the same cycle: write mem[wp], increment `wp`.
  - If full and no pop: drop the byte and set `overrun`. The byte is still acknowledged (go drops), so `UartRx` keeps running.
- Pop rules:
  - pop = `rd` && !empty: increment `rp`.
  - `rd` while empty is ignored. Pointers and `count` do not change, and no error is flagged.
- Count update: push only +1; pop only -1; accepted push and pop together, no change.
  - Full + push + pop: both happen, the byte is accepted, no overrun.
  - Empty + push + pop: the pop is ignored, the push happens, count becomes 1.
- Overrun:
  - Set has priority over `clr_overrun` in the same cycle.
  - Otherwise `clr_overrun` clears it.
  - The flag does not affect FIFO operation.

## Timing
- Reset, at the clock edge with `rst`=1:
  - wp=rp=0, count=0, state=RECV, `uartrx_go`=1, `overrun`=0.
  - Resulting outputs: `empty`=1, `full`=0, `dout`=0.
  - Array contents are don't-care.
  - Reset mid-transfer discards all stored bytes and any pending acknowledge.
- Push latency: byte sampled at edge N, where RECV and `uartrx_dr`=1.
  - From after edge N: visible on `dout` (if it becomes head), `empty`=0, `count` updated.
  - `uartrx_go`=0 during cycle N+1 and returns to 1 after edge N+1.
- Minimum spacing between accepted bytes is 2 cycles, far below the UART byte time.
- Pop latency: `rd` sampled at edge N; the next head byte, or 0, appears on `dout` after edge N.
- The read path samples `dout` before asserting `rd` for the same byte. Byte value and pop belong to the same read access.
- `rd` held high for k cycles pops min(k, count) bytes.

## Test plan
- Reset: after `rst` → `uartrx_go`=1, `empty`=1, `full`=0, `count`=0, `dout`=8'h00, `overrun`=0.
- Single byte:
  - Stimulus: `uartrx_dr`=1 with 8'h41 for 2 cycles.
  - Required: exactly one push; `uartrx_go` low for exactly one cycle; then `dout`=8'h41, `count`=1.
  - Then one `rd` pulse → `empty`=1, `dout`=8'h00.
- Order and wrap:
  - Stimulus: push 8'h00..8'h0F, pop all, push 8'h10..8'h15, pop all.
  - Required: popped bytes are strictly in push order across the pointer wrap; `count` returns to 0.
- Full/overrun:
  - Stimulus: push 17 bytes 8'h20..8'h30 without reading.
  - Required: `full`=1 and `count`=16 after byte 16. Byte 8'h30 is dropped and `overrun`=1, while `uartrx_go` still pulses low.
  - Draining yields 8'h20..8'h2F. `clr_overrun` then returns `overrun` to 0.
- Simultaneous events:
  - Full FIFO, push 8'h55 with `rd` in the same cycle → `count` stays 16, no overrun, 8'h55 is last out.
  - Empty FIFO, push 8'h66 with `rd` → `count`=1, `dout`=8'h66.
  - `overrun` set together with `clr_overrun` → `overrun`=1.
- Reset mid-operation: 5 bytes stored and the FSM in ACK, assert `rst` → `count`=0, `empty`=1, `uartrx_go`=1 on the next cycle; a subsequent push of 8'h77 reads back 8'h77.
